// File: rtl/gen_sim_play_if.sv
// ---------------------------------------------------------------------------
// gen_sim_play_if
// AXI-Stream style queue-word channel feeding the generator simulator.
//
// Signals:
//   tdata  [DW-1:0]  queue word (payload + length + mode flag)
//   tvalid           producer has a word this cycle
//   tready           consumer can accept a word this cycle
//
// Modports:
//   master  producer side (drives tdata/tvalid, reads tready)
//   slave   consumer side (reads tdata/tvalid, drives tready)
// ---------------------------------------------------------------------------
interface gen_sim_play_if #(
    parameter int DW = 160
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/gen_sim_play.sv
// ---------------------------------------------------------------------------
// gen_sim_play
// Cycle-accurate stand-in for a signal generator behind the tProc queue.
// Each accepted queue word is played on dout for len samples, where
// len = tdata[NW-1:0] (0 plays as 1). tdata[MODE_BIT] selects periodic
// (repeat the period until a new word arrives at a period boundary) or
// non-periodic (play once, then go idle with dout cleared).
//
// Parameters:
//   DW        queue word / dout width
//   NW        length field width (also the sample counter width)
//   MODE_BIT  bit index of the mode flag, NW <= MODE_BIT < DW
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   s_axis       queue word input channel (gen_sim_play_if.slave)
//   dout         word being played, zero when idle
//   dout_valid   dout carries a playing word
//   dout_last    final sample of the current period
//   busy         block is in PLAY
//   underflow_cnt, underflow   (only with GEN_SIM_PLAY_UNDERFLOW_EN)
//                saturating count / 1-cycle pulse of non-periodic words
//                that finished with no successor waiting
//
// Optional feature macro: GEN_SIM_PLAY_UNDERFLOW_EN
// ---------------------------------------------------------------------------
module gen_sim_play #(
    parameter int DW       = 160,
    parameter int NW       = 16,
    parameter int MODE_BIT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    gen_sim_play_if.slave s_axis,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_last,
`ifdef GEN_SIM_PLAY_UNDERFLOW_EN
    output logic [15:0]   underflow_cnt,
    output logic          underflow,
`endif
    output logic          busy
);

    if (MODE_BIT < NW || MODE_BIT >= DW) begin : g_param_check
        $error("gen_sim_play: MODE_BIT must satisfy NW <= MODE_BIT < DW");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    localparam logic [NW-1:0] L_ONE = {{(NW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [NW-1:0] r_cnt;
    logic [NW-1:0] r_len;
    logic          r_mode;
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;
`ifdef GEN_SIM_PLAY_UNDERFLOW_EN
    logic [15:0]   r_underflow_cnt;
    logic          r_underflow;
`endif

    logic          w_cnt_zero;
    logic          w_xfer;
    logic [NW-1:0] w_len;

    assign w_cnt_zero = (r_cnt == '0);

    // tready is a function of registered state only, so an upstream that
    // derives tvalid from tready can never close a combinational loop.
    assign s_axis.tready = (r_state == S_IDLE) || w_cnt_zero;
    assign w_xfer        = s_axis.tvalid && s_axis.tready;

    // A zero length field still plays one sample.
    assign w_len = (s_axis.tdata[NW-1:0] == '0) ? L_ONE : s_axis.tdata[NW-1:0];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation and mismatch synthesis.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_mode       <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
`ifdef GEN_SIM_PLAY_UNDERFLOW_EN
            r_underflow_cnt <= '0;
            r_underflow     <= 1'b0;
`endif
        end else begin
`ifdef GEN_SIM_PLAY_UNDERFLOW_EN
            r_underflow <= 1'b0;
`endif
            if (w_xfer) begin
                // Load a new word: from IDLE or gapless at a period boundary.
                r_state      <= S_PLAY;
                r_dout       <= s_axis.tdata;
                r_len        <= w_len;
                r_mode       <= s_axis.tdata[MODE_BIT];
                r_cnt        <= w_len - L_ONE;
                r_dout_valid <= 1'b1;
            end else if (r_state == S_PLAY) begin
                if (!w_cnt_zero) begin
                    r_cnt <= r_cnt - L_ONE;
                end else if (r_mode) begin
                    // Periodic: restart the period with no gap.
                    r_cnt <= r_len - L_ONE;
                end else begin
                    r_state      <= S_IDLE;
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
`ifdef GEN_SIM_PLAY_UNDERFLOW_EN
                    r_underflow <= 1'b1;
                    if (r_underflow_cnt != 16'hFFFF) begin
                        r_underflow_cnt <= r_underflow_cnt + 16'd1;
                    end
`endif
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = (r_state == S_PLAY);
    assign dout_last  = (r_state == S_PLAY) && w_cnt_zero;
`ifdef GEN_SIM_PLAY_UNDERFLOW_EN
    assign underflow_cnt = r_underflow_cnt;
    assign underflow     = r_underflow;
`endif

endmodule

// File: doc/gen_sim_play.md
Name: gen_sim_play

Overview:
- Parametrised successor to the single-register generator simulator.
- Accepts queue words over AXI-Stream and plays each word on `dout` for a programmed number of samples.
- Two modes per word: periodic (repeat until replaced) and non-periodic (play once, then idle).
- Sits behind the tProc signal-generator queue in simulation and bring-up builds, as a cycle-accurate stand-in for a real generator.

Parameters:
- DW, 160: data width of queue word and `dout`.
- NW, 16: width of length field; length = `tdata[NW-1:0]`.
- MODE_BIT, 16: bit index of mode flag (1 = periodic, 0 = non-periodic); must be ≥ NW and < DW.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  DW  queue word (payload + length + mode).
- s_axis_tvalid  in  1  queue word valid.
- s_axis_tready  out  1  block can accept a word this cycle.
- dout  out  DW  currently played word (zero when idle).
- dout_valid  out  1  `dout` carries a playing word.
- dout_last  out  1  high during final sample of current period.
- busy  out  1  state == PLAY.

Behaviour:
- One clock (`clk`); reset is asynchronous and active-low (`rstn`). Reset values: `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, state=IDLE, counter=0, latched length/mode=0.
- Handshake: word transferred on rising `clk` edge with `s_axis_tvalid` & `s_axis_tready`.
- `s_axis_tready` is combinational from registered state only, never from `tvalid`: high in IDLE, or in PLAY when counter==0.
- Load on transfer:
  - `dout` <= `tdata`.
  - len <= `tdata[NW-1:0]`, with len==0 treated as 1.
  - mode <= `tdata[MODE_BIT]`.
  - counter <= len-1.
  - `dout_valid` <= 1; state <= PLAY.
- Latency: word accepted at edge k appears on `dout` after edge k; it is held for exactly len cycles.
- PLAY, counter>0: counter decrements by 1 per cycle; `dout` held.
- PLAY, counter==0 (last sample; `dout_last`=1), next edge:
  - tvalid=1: load new word (gapless back-to-back); stay PLAY.
  - tvalid=0, mode=1: counter <= len-1; `dout` unchanged; period repeats with no gap.
  - tvalid=0, mode=0: state <= IDLE; `dout` <= 0; `dout_valid` <= 0.
- A periodic word runs indefinitely and is replaced only at a period boundary; words never preempt mid-period.
- `dout_last` = (state==PLAY) & (counter==0); combinational from registers.
- IDLE: `dout`=0, `dout_valid`=0, `dout_last`=0.
- Reset asserted mid-play: all outputs clear immediately (asynchronous); any in-flight word is dropped, not accepted.
- Reset release: first transfer possible on the first rising edge with `rstn` high.
- Counter is NW bits; max len 2^NW-1 = 65535 samples; no wrap-around possible.

Optional Feature:
- Macro: GEN_SIM_PLAY_UNDERFLOW_EN.
- Defined:
  - Adds output `underflow_cnt` [15:0] and output `underflow` (1-cycle pulse).
  - An underflow is a non-periodic word finishing (counter==0, mode=0) with tvalid=0.
  - Each underflow pulses `underflow` on the cycle the block enters IDLE and increments `underflow_cnt`, saturating at 0xFFFF.
  - Both reset to 0.
- Not defined: ports absent; behaviour otherwise identical.

Test Plan:
- Reset: hold `rstn`=0 with tvalid=1 -> tready may be 1 but no load; `dout`=0, `dout_valid`=0 after release until the first transfer.
- Non-periodic single: word payload 0xA5.., len=4, mode=0 -> `dout` = word for exactly 4 cycles, `dout_last` on 4th, then `dout`=0, `dout_valid`=0; tready=0 for cycles 1-3 of play.
- Gapless chain: len=3 mode=0, then len=2 mode=0 presented continuously -> 5 consecutive valid cycles, word change with no gap; `dout_last` at cycles 3 and 5.
- Periodic then replace: len=5 mode=1, next word len=1 mode=0 asserted mid-period at cycle 2 -> first word held until cycle 5 boundary, replacement plays 1 cycle, then idle.
- len=0 and max: len=0 -> plays 1 cycle; len=65535 mode=0 -> exactly 65535 valid cycles.
- Async reset mid-play (len=100, reset at cycle 40, off-edge) -> outputs 0 immediately; with GEN_SIM_PLAY_UNDERFLOW_EN, two back-to-back underflows -> `underflow_cnt`=2.
